// File: rtl/adt7420_i2c_responder.sv
// rtl/adt7420_i2c_responder.sv - I2C target emulating an ADT7420 temperature sensor
//
// Purpose: open-drain I2C target that serves a 13-bit temperature, a config register
// and an ID register, with a persistent auto-incrementing register pointer.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   scl_i    in   SCL pad input (asynchronous)
//   sda_i    in   SDA pad input (asynchronous)
//   sda_oe   out  1 = pull SDA low, 0 = release
//   temp_in  in   13-bit signed temperature, 0.0625 C/LSB
//   cfg_out  out  config register 0x03
//   busy     out  high from address match until STOP or repeated START
//   rd_done  out  1-cycle pulse when the master NACKs a read byte
module adt7420_i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter int         FILT     = 4,
    parameter logic [7:0] ID_VAL   = 8'hCB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [12:0] temp_in,
    output logic [7:0]  cfg_out,
    output logic        busy,
    output logic        rd_done
);

    localparam int CW = $clog2(FILT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WR,
        S_WR_ACK,
        S_TX,
        S_MACK
    } state_t;

    // Index 0 = SCL, index 1 = SDA
    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_filt;
    logic [1:0]    r_filt_d;
    logic [CW-1:0] r_fcnt [2];
    logic          r_fall_d;

    state_t        r_state;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_rd_done;
    logic [7:0]    r_cfg;
    logic [7:0]    r_ptr;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_rw;
    logic          r_ack_phase;
    logic          r_load;
    logic [15:0]   r_shadow;

    logic          w_scl;
    logic          w_sda;
    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic [7:0]    w_byte_in;
    logic [7:0]    w_rd_byte;

    // Synchronizer plus stability filter: a new level is accepted only after it has
    // been seen on the synchronized pin for FILT consecutive cycles. Idle bus is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta    <= 2'b11;
            r_sync    <= 2'b11;
            r_filt    <= 2'b11;
            r_filt_d  <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
            r_fall_d  <= 1'b0;
        end else begin
            r_meta   <= {sda_i, scl_i};
            r_sync   <= r_meta;
            r_filt_d <= r_filt;
            r_fall_d <= w_scl_fall;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == CW'(FILT - 1)) begin
                    r_filt[i] <= r_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_scl      = r_filt[0];
    assign w_sda      = r_filt[1];
    assign w_scl_rise = w_scl & ~r_filt_d[0];
    assign w_scl_fall = ~w_scl & r_filt_d[0];
    assign w_start    = w_scl & r_filt_d[0] & r_filt_d[1] & ~w_sda;
    assign w_stop     = w_scl & r_filt_d[0] & ~r_filt_d[1] & w_sda;
    assign w_byte_in  = {r_shift[6:0], w_sda};

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_ptr)
            8'h00:   w_rd_byte = r_shadow[15:8];
            8'h01:   w_rd_byte = r_shadow[7:0];
            8'h02:   w_rd_byte = 8'h00;
            8'h03:   w_rd_byte = r_cfg;
            8'h0B:   w_rd_byte = ID_VAL;
            default: w_rd_byte = 8'h00;
        endcase
    end

    // SDA is only ever updated on r_fall_d, one clk after a filtered SCL fall, so the
    // target never moves SDA while SCL is high and cannot fake a START/STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_done   <= 1'b0;
            r_cfg       <= 8'h00;
            r_ptr       <= 8'h00;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_rw        <= 1'b0;
            r_ack_phase <= 1'b0;
            r_load      <= 1'b0;
            r_shadow    <= 16'h0000;
        end else begin
            r_rd_done <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_load    <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_ADDR, S_PTR, S_WR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ack_phase <= 1'b0;
                                case (r_state)
                                    S_ADDR: begin
                                        if (w_byte_in[7:1] == DEV_ADDR) begin
                                            r_state <= S_ADDR_ACK;
                                            r_rw    <= w_byte_in[0];
                                            r_busy  <= 1'b1;
                                            // Snapshot keeps MSB/LSB coherent for the whole read
                                            if (w_byte_in[0]) begin
                                                r_shadow <= {temp_in, 3'b000};
                                            end
                                        end else begin
                                            r_state <= S_IDLE;
                                            r_busy  <= 1'b0;
                                        end
                                    end
                                    S_PTR: begin
                                        r_ptr   <= w_byte_in;
                                        r_state <= S_PTR_ACK;
                                    end
                                    default: begin
                                        if (r_ptr == 8'h03) begin
                                            r_cfg <= w_byte_in;
                                        end
                                        r_ptr   <= r_ptr + 8'd1;
                                        r_state <= S_WR_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // First fall after the 8th bit: pull SDA low. Second fall (after the
                    // 9th clock): release, or put the first read bit straight on the bus.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (r_fall_d) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_ack_phase <= 1'b0;
                                r_bit_cnt   <= 3'd0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_state  <= S_TX;
                                    r_sda_oe <= ~w_rd_byte[7];
                                    r_shift  <= {w_rd_byte[6:0], 1'b0};
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WR;
                                end
                            end
                        end
                    end
                    S_TX: begin
                        if (r_fall_d) begin
                            if (r_load) begin
                                r_sda_oe <= ~w_rd_byte[7];
                                r_shift  <= {w_rd_byte[6:0], 1'b0};
                                r_load   <= 1'b0;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                            end
                        end
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_MACK;
                            end
                        end
                    end
                    S_MACK: begin
                        if (r_fall_d) begin
                            r_sda_oe <= 1'b0;
                        end
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_ptr   <= r_ptr + 8'd1;
                                r_load  <= 1'b1;
                                r_state <= S_TX;
                            end else begin
                                r_rd_done <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign rd_done = r_rd_done;
    assign cfg_out = r_cfg;

endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// tb/tb_adt7420_i2c_responder.sv - directed bench for adt7420_i2c_responder
module tb_adt7420_i2c_responder;

    localparam int Q = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [12:0] temp_in = 13'h0190;
    logic        sda_oe;
    logic [7:0]  cfg_out;
    logic        busy;
    logic        rd_done;
    logic        w_sda_bus;

    int n_vec = 0;
    int n_err = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int rdd_cnt = 0;
    int viol = 0;
    logic oe_prev = 1'b0;
    logic scl_prev = 1'b1;

    assign w_sda_bus = m_sda & ~sda_oe;

    adt7420_i2c_responder dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (m_scl),
        .sda_i   (w_sda_bus),
        .sda_oe  (sda_oe),
        .temp_in (temp_in),
        .cfg_out (cfg_out),
        .busy    (busy),
        .rd_done (rd_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rd_done) rdd_cnt <= rdd_cnt + 1;
        if (rst && scl_prev && m_scl && (sda_oe !== oe_prev)) viol <= viol + 1;
        oe_prev  <= sda_oe;
        scl_prev <= m_scl;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b1; wq(Q);
    endtask

    // g inserts one-clk SCL glitches in both the low and the high phase
    task automatic write_bit(input logic b, input logic g);
        m_sda = b;
        if (g) begin
            wq(5); m_scl = 1'b1; wq(1); m_scl = 1'b0; wq(Q - 6);
        end else begin
            wq(Q);
        end
        m_scl = 1'b1;
        if (g) begin
            wq(Q); m_scl = 1'b0; wq(1); m_scl = 1'b1; wq(Q - 1);
        end else begin
            wq(2 * Q);
        end
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        b = w_sda_bus; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic g, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], g);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [3:0] nib;
        logic       b;
        int         c0;
        int         c1;

        wq(5);
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_rd_done", {15'd0, rd_done}, 16'd0);
        check("rst_cfg", {8'd0, cfg_out}, 16'h0000);
        rst = 1'b1;
        wq(10);

        // 1: pointer write 0x00, repeated START, read two temperature bytes
        i2c_start;
        write_byte(8'h96, 1'b0, ack); check("t1_ack_addr_w", {15'd0, ack}, 16'd0);
        check("t1_busy", {15'd0, busy}, 16'd1);
        write_byte(8'h00, 1'b0, ack); check("t1_ack_ptr", {15'd0, ack}, 16'd0);
        i2c_start;
        write_byte(8'h97, 1'b0, ack); check("t1_ack_addr_r", {15'd0, ack}, 16'd0);
        c0 = rdd_cnt;
        read_byte(1'b0, d); check("t1_msb", {8'd0, d}, 16'h000C);
        read_byte(1'b1, d); check("t1_lsb", {8'd0, d}, 16'h0080);
        i2c_stop;
        check("t1_rd_done_pulse", 16'(rdd_cnt - c0), 16'd1);
        check("t1_busy_after_stop", {15'd0, busy}, 16'd0);

        // 2: foreign address is ignored
        c0 = oe_cnt;
        c1 = busy_cnt;
        i2c_start;
        write_byte(8'h90, 1'b0, ack); check("t2_nack_addr", {15'd0, ack}, 16'd1);
        write_byte(8'h00, 1'b0, ack); check("t2_nack_data", {15'd0, ack}, 16'd1);
        i2c_stop;
        check("t2_no_sda_drive", 16'(oe_cnt - c0), 16'd0);
        check("t2_no_busy", 16'(busy_cnt - c1), 16'd0);

        // 3: config write, then ID read
        i2c_start;
        write_byte(8'h96, 1'b0, ack); check("t3_ack_addr", {15'd0, ack}, 16'd0);
        write_byte(8'h03, 1'b0, ack); check("t3_ack_ptr", {15'd0, ack}, 16'd0);
        write_byte(8'hA0, 1'b0, ack); check("t3_ack_data", {15'd0, ack}, 16'd0);
        check("t3_cfg", {8'd0, cfg_out}, 16'h00A0);
        i2c_stop;
        i2c_start;
        write_byte(8'h96, 1'b0, ack); check("t3_ack_addr2", {15'd0, ack}, 16'd0);
        write_byte(8'h0B, 1'b0, ack); check("t3_ack_ptr2", {15'd0, ack}, 16'd0);
        i2c_start;
        write_byte(8'h97, 1'b0, ack); check("t3_ack_addr_r", {15'd0, ack}, 16'd0);
        read_byte(1'b1, d); check("t3_id", {8'd0, d}, 16'h00CB);
        i2c_stop;
        check("t3_cfg_kept", {8'd0, cfg_out}, 16'h00A0);

        // 4: shadow coherence across a mid-read temperature change
        i2c_start;
        write_byte(8'h96, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        i2c_start;
        write_byte(8'h97, 1'b0, ack);
        read_byte(1'b0, d); check("t4_msb_old", {8'd0, d}, 16'h000C);
        temp_in = 13'h1FF0;
        read_byte(1'b1, d); check("t4_lsb_coherent", {8'd0, d}, 16'h0080);
        i2c_stop;
        i2c_start;
        write_byte(8'h96, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        i2c_start;
        write_byte(8'h97, 1'b0, ack);
        read_byte(1'b0, d); check("t4_msb_new", {8'd0, d}, 16'h00FF);
        read_byte(1'b1, d); check("t4_lsb_new", {8'd0, d}, 16'h0080);
        i2c_stop;

        // 5: reset while the target drives bit 3 (a 0) of cfg 0xA0
        i2c_start;
        write_byte(8'h96, 1'b0, ack);
        write_byte(8'h03, 1'b0, ack);
        i2c_start;
        write_byte(8'h97, 1'b0, ack); check("t5_ack_addr_r", {15'd0, ack}, 16'd0);
        for (int i = 3; i >= 0; i--) begin
            read_bit(b);
            nib[i] = b;
        end
        check("t5_upper_nibble", {12'd0, nib}, 16'h000A);
        check("t5_driving_bit3", {15'd0, sda_oe}, 16'd1);
        rst = 1'b0;
        #1;
        check("t5_sda_released", {15'd0, sda_oe}, 16'd0);
        check("t5_cfg_cleared", {8'd0, cfg_out}, 16'h0000);
        check("t5_busy_cleared", {15'd0, busy}, 16'd0);
        wq(3);
        rst = 1'b1;
        wq(Q);
        i2c_stop;
        i2c_start;
        write_byte(8'h97, 1'b0, ack); check("t5_ack_after_rst", {15'd0, ack}, 16'd0);
        read_byte(1'b0, d); check("t5_msb", {8'd0, d}, 16'h00FF);
        read_byte(1'b1, d); check("t5_lsb", {8'd0, d}, 16'h0080);
        i2c_stop;

        // 6: short SCL glitches during the address byte
        i2c_start;
        write_byte(8'h96, 1'b1, ack); check("t6_ack_glitch_w", {15'd0, ack}, 16'd0);
        write_byte(8'h01, 1'b0, ack); check("t6_ack_ptr", {15'd0, ack}, 16'd0);
        i2c_start;
        write_byte(8'h97, 1'b1, ack); check("t6_ack_glitch_r", {15'd0, ack}, 16'd0);
        read_byte(1'b1, d); check("t6_lsb", {8'd0, d}, 16'h0080);
        i2c_stop;

        check("sda_stable_while_scl_high", 16'(viol), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
